vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing in the pixel-clock domain produced by the 12 MHz -> 25.125 MHz PLL. It qualifies the PLL lock indication before starting the raster, and restarts cleanly whenever lock is lost. It drives the sync pins and supplies pixel coordinates plus line and frame strobes to the video-RAM reader and the pixel pipeline.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- LOCK_WAIT, 16, consecutive locked cycles required before the raster starts (1..255)

Ports:
- clk  in  1  pixel clock (PLL output, 25.125 MHz)
- reset  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock indication; treated as already synchronous to clk
- running  out  1  raster active (lock qualified)
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high while pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when pixel_x == 0 (every line)
- frame_start  out  1  one-cycle pulse when pixel_x == 0 and pixel_y == 0

## Operation
- Derived constants: H_TOTAL = sum of the H parameters (800 by default); V_TOTAL = sum of the V parameters (525 by default). Counters are 10 bits, so both totals must be ≤ 1024.
- The block has two states, WAIT_LOCK and RUN.
- WAIT_LOCK:
  - An 8-bit lock counter increments on every cycle with pll_locked = 1.
  - The lock counter clears on any cycle with pll_locked = 0.
  - When the counter reaches LOCK_WAIT-1 while pll_locked = 1, the next state is RUN.
  - The raster counters are held at 0 and all outputs stay at their idle values.
- RUN:
  - pixel_x increments every cycle and wraps from H_TOTAL-1 to 0.
  - On that wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
- Loss of lock: pll_locked = 0 in RUN returns the block to WAIT_LOCK on the next edge. The raster counters, lock counter and outputs return to their idle values, and no partial strobes are generated. The next RUN entry starts again at (0,0) with frame_start.
- Sync windows:
  - hsync = 0 for H_VISIBLE+H_FRONT ≤ pixel_x < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync = 0 for V_VISIBLE+V_FRONT ≤ pixel_y < V_VISIBLE+V_FRONT+V_SYNC. vsync is evaluated on whole lines, so its edges coincide with pixel_x = 0.
- Idle output values (reset, and all of WAIT_LOCK): running = 0, hsync = 1, vsync = 1, display_on = 0, pixel_x = 0, pixel_y = 0, line_start = 0, frame_start = 0.

## Timing
- All outputs are registered. hsync, vsync, display_on, line_start and frame_start are computed from the next-state counter values, so in any given cycle they describe the pixel_x/pixel_y shown in that same cycle. Combinational latency is zero.
- reset has priority over pll_locked. While reset is asserted, all outputs take their idle values at the next edge, from any state.
- Lock qualification, with pll_locked held high from cycle 0: running rises at the edge ending cycle LOCK_WAIT-1. In that first RUN cycle, pixel_x = 0, pixel_y = 0, frame_start = 1, line_start = 1 and display_on = 1.
- Frame period is H_TOTAL*V_TOTAL cycles (420000 by default). frame_start is high for exactly one cycle per frame; line_start is high for exactly one cycle per line.
- A one-cycle drop of pll_locked in WAIT_LOCK restarts the full LOCK_WAIT qualification.

## Test plan
- Reset, then pll_locked = 1 from cycle 0 with LOCK_WAIT = 16 -> outputs idle for 16 cycles; running = 1 with frame_start = 1 at (0,0) on the 17th cycle.
- One full line in RUN -> display_on high for exactly 640 cycles; hsync low for exactly 96 cycles starting at pixel_x = 656; line_start pulses at 0 and again 800 cycles later.
- One full frame -> vsync low exactly from pixel_y = 490 (pixel_x = 0) through the end of pixel_y = 491; frame_start pulses are 420000 cycles apart; pixel_y wraps 524 -> 0.
- Drop pll_locked for 1 cycle at (300,200) -> next cycle idle outputs, running = 0; after relock, a 16-cycle wait, then restart at (0,0) with frame_start.
- Assert reset at (799,524) while locked -> idle outputs next cycle; no wrap strobe; requalification required after reset is released.
- pll_locked toggling every 8 cycles with LOCK_WAIT = 16 -> running never rises; all outputs remain idle.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: sync pins, pixel coordinates and line/frame strobes.
interface vga_timing_gen_if;
  logic       running;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;

  modport master (output running, hsync, vsync, display_on, pixel_x, pixel_y,
                  line_start, frame_start);
  modport slave  (input  running, hsync, vsync, display_on, pixel_x, pixel_y,
                  line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator, gated by a qualified PLL lock.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int LOCK_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
  vga_timing_gen_if.master  vid
);

  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_WAIT - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t     state, state_nx;
  logic [7:0] lock_cnt, lock_cnt_nx;
  logic [9:0] x_nx, y_nx;
  logic       run_nx, hs_nx, vs_nx, de_nx, ls_nx, fs_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_LOCK;
      lock_cnt        <= '0;
      vid.running     <= 1'b0;
      vid.hsync       <= 1'b1;
      vid.vsync       <= 1'b1;
      vid.display_on  <= 1'b0;
      vid.pixel_x     <= '0;
      vid.pixel_y     <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      state           <= state_nx;
      lock_cnt        <= lock_cnt_nx;
      vid.running     <= run_nx;
      vid.hsync       <= hs_nx;
      vid.vsync       <= vs_nx;
      vid.display_on  <= de_nx;
      vid.pixel_x     <= x_nx;
      vid.pixel_y     <= y_nx;
      vid.line_start  <= ls_nx;
      vid.frame_start <= fs_nx;
    end
  end

  // Counters fall back to 0 on any path that is not a continuing RUN cycle.
  always_comb begin
    state_nx    = state;
    lock_cnt_nx = '0;
    x_nx        = '0;
    y_nx        = '0;
    case (state)
      WAIT_LOCK: begin
        if (pll_locked) begin
          if (lock_cnt == LOCK_LAST) state_nx = RUN;
          else                       lock_cnt_nx = lock_cnt + 8'd1;
        end
      end
      RUN: begin
        if (!pll_locked) begin
          state_nx = WAIT_LOCK;
        end else if (vid.pixel_x == H_LAST) begin
          y_nx = (vid.pixel_y == V_LAST) ? 10'd0 : vid.pixel_y + 10'd1;
        end else begin
          x_nx = vid.pixel_x + 10'd1;
          y_nx = vid.pixel_y;
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  // Decode from next-state coordinates so registered outputs line up with pixel_x/y.
  always_comb begin
    run_nx = (state_nx == RUN);
    hs_nx  = 1'b1;
    vs_nx  = 1'b1;
    de_nx  = 1'b0;
    ls_nx  = 1'b0;
    fs_nx  = 1'b0;
    if (run_nx) begin
      hs_nx = !(x_nx >= HS_BEG && x_nx < HS_END);
      vs_nx = !(y_nx >= VS_BEG && y_nx < VS_END);
      de_nx = (x_nx < H_VIS) && (y_nx < V_VIS);
      ls_nx = (x_nx == 10'd0);
      fs_nx = (x_nx == 10'd0) && (y_nx == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_vga_timing_gen;
  localparam int HV = 20, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int LW = 16;
  localparam int HT = HV + HF + HS + HB;   // 34
  localparam int VT = VV + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 646

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;

  vga_timing_gen_if vid();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .vid(vid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a streak of locked cycles qualifies the raster; once running,
  // position is simply elapsed cycles modulo the frame.
  bit m_run = 0;
  int m_streak = 0;
  int m_t = 0;
  bit armed = 0;

  always @(posedge clk) begin
    armed = 1;
    if (reset) begin
      m_run = 0; m_streak = 0; m_t = 0;
    end else if (!m_run) begin
      if (pll_locked) begin
        m_streak++;
        if (m_streak == LW) begin m_run = 1; m_streak = 0; m_t = 0; end
      end else m_streak = 0;
    end else if (!pll_locked) begin
      m_run = 0; m_streak = 0; m_t = 0;
    end else begin
      m_t = (m_t + 1) % FRAME;
    end
  end

  always @(negedge clk) begin : cmp
    int ex, ey;
    if (armed) begin
      ex = m_run ? m_t % HT : 0;
      ey = m_run ? m_t / HT : 0;
      chk("running",    32'(vid.running), 32'(m_run));
      chk("pixel_x",    32'(vid.pixel_x), 32'(ex));
      chk("pixel_y",    32'(vid.pixel_y), 32'(ey));
      chk("hsync",      32'(vid.hsync),
          32'(!(m_run && ex >= HV + HF && ex < HV + HF + HS)));
      chk("vsync",      32'(vid.vsync),
          32'(!(m_run && ey >= VV + VF && ey < VV + VF + VS)));
      chk("display_on", 32'(vid.display_on), 32'(m_run && ex < HV && ey < VV));
      chk("line_start", 32'(vid.line_start), 32'(m_run && ex == 0));
      chk("frame_start",32'(vid.frame_start),32'(m_run && ex == 0 && ey == 0));
    end
  end

  // Expects pll_locked to have just been driven high: 15 more idle cycles, then RUN at (0,0).
  task automatic qualify(input string tag);
    repeat (LW - 1) begin
      @(negedge clk);
      chk({tag, "_wait_running"}, 32'(vid.running), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_running"},     32'(vid.running), 32'd1);
    chk({tag, "_frame_start"}, 32'(vid.frame_start), 32'd1);
    chk({tag, "_line_start"},  32'(vid.line_start), 32'd1);
    chk({tag, "_display_on"},  32'(vid.display_on), 32'd1);
    chk({tag, "_xy"}, {6'd0, vid.pixel_y, 6'd0, vid.pixel_x}, 32'd0);
  endtask

  task automatic wait_xy(input int x, input int y);
    int budget = 4 * FRAME;
    while (!(vid.running && vid.pixel_x == 10'(x) && vid.pixel_y == 10'(y)) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("wait_xy_timeout", 32'(budget == 0), 32'd0);
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt, hs_first_x, vs_first_y;
    repeat (3) @(negedge clk);
    chk("reset_running", 32'(vid.running), 32'd0);
    chk("reset_hsync",   32'(vid.hsync), 32'd1);
    chk("reset_vsync",   32'(vid.vsync), 32'd1);

    // Lock qualification straight out of reset.
    reset = 1'b0; pll_locked = 1'b1;
    qualify("boot");

    // One whole frame of literal counts.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    hs_first_x = -1; vs_first_y = -1;
    for (int c = 0; c < FRAME; c++) begin
      de_cnt += int'(vid.display_on);
      ls_cnt += int'(vid.line_start);
      fs_cnt += int'(vid.frame_start);
      if (!vid.hsync) begin
        hs_cnt++;
        if (hs_first_x < 0) hs_first_x = int'(vid.pixel_x);
      end
      if (!vid.vsync) begin
        vs_cnt++;
        if (vs_first_y < 0) begin
          vs_first_y = int'(vid.pixel_y);
          chk("vsync_edge_x", 32'(vid.pixel_x), 32'd0);
        end
      end
      @(negedge clk);
    end
    chk("frame_display_cnt", 32'(de_cnt), 32'd240);
    chk("frame_hsync_cnt",   32'(hs_cnt), 32'd114);
    chk("frame_vsync_cnt",   32'(vs_cnt), 32'd68);
    chk("frame_line_cnt",    32'(ls_cnt), 32'd19);
    chk("frame_start_cnt",   32'(fs_cnt), 32'd1);
    chk("hsync_first_x",     32'(hs_first_x), 32'd24);
    chk("vsync_first_y",     32'(vs_first_y), 32'd14);
    chk("frame_wrap_fs",     32'(vid.frame_start), 32'd1);
    chk("frame_wrap_y",      32'(vid.pixel_y), 32'd0);

    // One-cycle lock drop mid-frame.
    wait_xy(10, 5);
    pll_locked = 1'b0;
    @(negedge clk);
    chk("drop_running", 32'(vid.running), 32'd0);
    chk("drop_x",       32'(vid.pixel_x), 32'd0);
    chk("drop_fs",      32'(vid.frame_start), 32'd0);
    pll_locked = 1'b1;
    qualify("relock");

    // Reset on the last pixel of the frame.
    wait_xy(HT - 1, VT - 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_running", 32'(vid.running), 32'd0);
    chk("rst_fs",      32'(vid.frame_start), 32'd0);
    chk("rst_ls",      32'(vid.line_start), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    qualify("post_reset");

    // Lock toggling every 8 cycles never qualifies.
    for (int c = 0; c < 160; c++) begin
      pll_locked = ((c / 8) % 2) == 1;
      @(negedge clk);
      chk("toggle_running", 32'(vid.running), 32'd0);
    end

    // Random lock drops and occasional resets, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      pll_locked = ($urandom_range(0, 499) != 0);
      reset      = ($urandom_range(0, 1999) == 0);
      @(negedge clk);
    end
    reset = 1'b0; pll_locked = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
